// File: rtl/cr16_pkg.sv
// Shared CR16 controller types: FSM states, instruction classes,
// ALU opcodes, branch condition codes and flag bit positions.
package cr16_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WRITEBACK
   } state_e;

   typedef enum logic [2:0] {
      CL_NOP,
      CL_ALU,
      CL_LOAD,
      CL_STOR,
      CL_JAL,
      CL_JCOND,
      CL_BCOND
   } iclass_e;

   localparam logic [3:0] OP_REG     = 4'b0000;
   localparam logic [3:0] OP_SPECIAL = 4'b0100;
   localparam logic [3:0] OP_BCOND   = 4'b1100;

   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   localparam logic [3:0] ALU_AND  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_XOR  = 4'b0011;
   localparam logic [3:0] ALU_ADD  = 4'b0101;
   localparam logic [3:0] ALU_ADDU = 4'b0110;
   localparam logic [3:0] ALU_ADDC = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1001;
   localparam logic [3:0] ALU_SUBC = 4'b1010;
   localparam logic [3:0] ALU_CMP  = 4'b1011;
   localparam logic [3:0] ALU_MOV  = 4'b1101;
   localparam logic [3:0] ALU_LUI  = 4'b1111;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_HI = 4'h4;
   localparam logic [3:0] COND_LS = 4'h5;
   localparam logic [3:0] COND_GT = 4'h6;
   localparam logic [3:0] COND_LE = 4'h7;
   localparam logic [3:0] COND_FS = 4'h8;
   localparam logic [3:0] COND_FC = 4'h9;
   localparam logic [3:0] COND_LO = 4'hA;
   localparam logic [3:0] COND_HS = 4'hB;
   localparam logic [3:0] COND_LT = 4'hC;
   localparam logic [3:0] COND_GE = 4'hD;
   localparam logic [3:0] COND_UC = 4'hE;

   localparam int F_N = 4;
   localparam int F_Z = 3;
   localparam int F_F = 2;
   localparam int F_L = 1;
   localparam int F_C = 0;

   function automatic logic is_alu(input logic [3:0] op);
      return op inside {ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_ADDU,
                        ALU_ADDC, ALU_SUB, ALU_SUBC, ALU_CMP, ALU_MOV};
   endfunction

   function automatic logic cond_true(input logic [3:0] c,
                                      input logic [4:0] f);
      logic t;
      t = 1'b0;
      case (c)
         COND_EQ: t = f[F_Z];
         COND_NE: t = !f[F_Z];
         COND_CS: t = f[F_C];
         COND_CC: t = !f[F_C];
         COND_HI: t = f[F_L];
         COND_LS: t = !f[F_L];
         COND_GT: t = f[F_N];
         COND_LE: t = !f[F_N];
         COND_FS: t = f[F_F];
         COND_FC: t = !f[F_F];
         COND_LO: t = !f[F_L] && !f[F_Z];
         COND_HS: t = f[F_L] || f[F_Z];
         COND_LT: t = !f[F_N] && !f[F_Z];
         COND_GE: t = f[F_N] || f[F_Z];
         COND_UC: t = 1'b1;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/control_fsm_decoder.sv
// Combinational CR16 instruction decoder: class, ALU opcode,
// extended immediate, Rdest write flag and branch condition.
module control_fsm_decoder
   import cr16_pkg::*;
(
   input  logic [15:0] ir_i,
   output iclass_e     cls_o,
   output logic [3:0]  alu_op_o,
   output logic [15:0] imm_o,
   output logic        imm_sel_o,
   output logic        wr_rd_o,
   output logic [3:0]  cond_o
);

   logic [3:0] op;
   logic [3:0] ext;

   assign op     = ir_i[15:12];
   assign ext    = ir_i[7:4];
   assign cond_o = ir_i[11:8];

   always_comb begin
      cls_o     = CL_NOP;
      alu_op_o  = ext;
      imm_o     = {{8{ir_i[7]}}, ir_i[7:0]};
      imm_sel_o = 1'b0;
      wr_rd_o   = 1'b0;
      unique case (1'b1)
         op == OP_REG: begin
            if (is_alu(ext)) begin
               cls_o   = CL_ALU;
               wr_rd_o = ext != ALU_CMP;
            end
         end
         op == OP_SPECIAL: begin
            case (ext)
               EXT_LOAD: begin
                  cls_o   = CL_LOAD;
                  wr_rd_o = 1'b1;
               end
               EXT_STOR:  cls_o = CL_STOR;
               EXT_JAL: begin
                  cls_o   = CL_JAL;
                  wr_rd_o = 1'b1;
               end
               EXT_JCOND: cls_o = CL_JCOND;
               default:   cls_o = CL_NOP;
            endcase
         end
         op == OP_BCOND: cls_o = CL_BCOND;
         default: begin
            alu_op_o  = op;
            imm_sel_o = 1'b1;
            if (is_alu(op) || op == ALU_LUI) begin
               cls_o   = CL_ALU;
               wr_rd_o = op != ALU_CMP;
            end
            // Logical immediates are unsigned; LUI fills the high byte.
            if (op inside {ALU_AND, ALU_OR, ALU_XOR})
               imm_o = {8'h00, ir_i[7:0]};
            else if (op == ALU_LUI)
               imm_o = {ir_i[7:0], 8'h00};
         end
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CR16 controller: owns PC and IR, sequences
// fetch/decode/execute/memory/writeback and drives the datapath.
module control_fsm
   import cr16_pkg::*;
#(
   parameter int                    P_ADDR_WIDTH = 16,
   parameter logic [P_ADDR_WIDTH-1:0] P_RESET_PC = '0
) (
   input  logic                    I_CLK,
   input  logic                    I_NRESET,
   input  logic                    I_ENABLE,
   input  logic [15:0]             I_MEM_DATA,
   input  logic [4:0]              I_STATUS_FLAGS,
   input  logic [15:0]             I_B,
   output logic [P_ADDR_WIDTH-1:0] O_MEM_ADDR,
   output logic                    O_MEM_WRITE_ENABLE,
   output logic [15:0]             O_REG_WRITE_ENABLE,
   output logic [3:0]              O_REG_A_SELECT,
   output logic [3:0]              O_REG_B_SELECT,
   output logic [15:0]             O_IMMEDIATE,
   output logic                    O_IMMEDIATE_SELECT,
   output logic [3:0]              O_OPCODE,
   output logic                    O_STATUS_FLAGS_SELECT,
   output logic [15:0]             O_REGFILE_DATA,
   output logic                    O_REGFILE_DATA_SELECT,
   output logic [P_ADDR_WIDTH-1:0] O_PC
);

   typedef logic [P_ADDR_WIDTH-1:0] addr_t;

   state_e state_q, state_d;
   addr_t  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;

   iclass_e    cls;
   logic [3:0] alu_op;
   logic [15:0] imm;
   logic       imm_sel;
   logic       wr_rd;
   logic [3:0] cond;

   control_fsm_decoder u_dec (
      .ir_i      (ir_q),
      .cls_o     (cls),
      .alu_op_o  (alu_op),
      .imm_o     (imm),
      .imm_sel_o (imm_sel),
      .wr_rd_o   (wr_rd),
      .cond_o    (cond)
   );

   addr_t       pc_inc;
   addr_t       b_addr;
   logic [15:0] rd_hot;
   logic        taken;
   addr_t       mem_addr;
   logic        mem_we;
   logic [15:0] reg_we;
   logic        flags_sel;
   logic [15:0] rf_data;
   logic        rf_sel;

   assign pc_inc = pc_q + addr_t'(1);
   assign b_addr = I_B[P_ADDR_WIDTH-1:0];
   assign rd_hot = 16'(1) << ir_q[11:8];
   assign taken  = cond_true(cond, I_STATUS_FLAGS);

   always_ff @(posedge I_CLK or negedge I_NRESET) begin
      if (!I_NRESET) begin
         state_q <= S_FETCH;
         pc_q    <= P_RESET_PC;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      mem_addr  = pc_q;
      mem_we    = 1'b0;
      reg_we    = '0;
      flags_sel = 1'b1;
      rf_data   = '0;
      rf_sel    = 1'b0;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d    = I_MEM_DATA;
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            state_d = S_FETCH;
            pc_d    = pc_inc;
            unique case (cls)
               CL_ALU: begin
                  flags_sel = 1'b0;
                  if (wr_rd) reg_we = rd_hot;
               end
               CL_LOAD, CL_STOR: begin
                  pc_d    = pc_q;
                  state_d = S_MEM;
               end
               CL_BCOND: begin
                  if (taken)
                     pc_d = pc_q + addr_t'($signed(ir_q[7:0]));
               end
               CL_JCOND: begin
                  if (taken) pc_d = b_addr;
               end
               CL_JAL: begin
                  rf_data = 16'(pc_inc);
                  rf_sel  = 1'b1;
                  reg_we  = rd_hot;
                  pc_d    = b_addr;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_addr = b_addr;
            if (cls == CL_STOR) begin
               mem_we  = 1'b1;
               pc_d    = pc_inc;
               state_d = S_FETCH;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            // Keep the load address so stalled cycles see stable data.
            mem_addr = b_addr;
            rf_data  = I_MEM_DATA;
            rf_sel   = 1'b1;
            reg_we   = rd_hot;
            pc_d     = pc_inc;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (!I_ENABLE) begin
         state_d   = state_q;
         pc_d      = pc_q;
         ir_d      = ir_q;
         mem_we    = 1'b0;
         reg_we    = '0;
         flags_sel = 1'b1;
      end
   end

   // Outputs drop combinationally with reset so a store strobe aborts.
   assign O_MEM_ADDR            = I_NRESET ? mem_addr : P_RESET_PC;
   assign O_MEM_WRITE_ENABLE    = I_NRESET & mem_we;
   assign O_REG_WRITE_ENABLE    = I_NRESET ? reg_we : '0;
   assign O_REG_A_SELECT        = I_NRESET ? ir_q[11:8] : '0;
   assign O_REG_B_SELECT        = I_NRESET ? ir_q[3:0] : '0;
   assign O_IMMEDIATE           = I_NRESET ? imm : '0;
   assign O_IMMEDIATE_SELECT    = I_NRESET & imm_sel;
   assign O_OPCODE              = I_NRESET ? alu_op : '0;
   assign O_STATUS_FLAGS_SELECT = I_NRESET & flags_sel;
   assign O_REGFILE_DATA        = I_NRESET ? rf_data : '0;
   assign O_REGFILE_DATA_SELECT = I_NRESET & rf_sel;
   assign O_PC                  = I_NRESET ? pc_q : P_RESET_PC;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks a fixed program through
// ALU, immediate, load/store, branch, JAL, stall, wrap and reset.
module tb_control_fsm;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [15:0] mem_q;
   logic [4:0]  fl;
   logic [15:0] ib;
   logic [15:0] addr;
   logic        mem_we;
   logic [15:0] reg_we;
   logic [3:0]  a_sel;
   logic [3:0]  b_sel;
   logic [15:0] imm;
   logic        imm_sel;
   logic [3:0]  opc;
   logic        fl_sel;
   logic [15:0] rf_data;
   logic        rf_sel;
   logic [15:0] pc;

   logic [15:0] mem [0:1023];
   int          n_run;
   int          n_fail;
   int          n_strobe;

   control_fsm dut (
      .I_CLK                 (clk),
      .I_NRESET              (rst_n),
      .I_ENABLE              (en),
      .I_MEM_DATA            (mem_q),
      .I_STATUS_FLAGS        (fl),
      .I_B                   (ib),
      .O_MEM_ADDR            (addr),
      .O_MEM_WRITE_ENABLE    (mem_we),
      .O_REG_WRITE_ENABLE    (reg_we),
      .O_REG_A_SELECT        (a_sel),
      .O_REG_B_SELECT        (b_sel),
      .O_IMMEDIATE           (imm),
      .O_IMMEDIATE_SELECT    (imm_sel),
      .O_OPCODE              (opc),
      .O_STATUS_FLAGS_SELECT (fl_sel),
      .O_REGFILE_DATA        (rf_data),
      .O_REGFILE_DATA_SELECT (rf_sel),
      .O_PC                  (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) mem_q <= mem[addr[9:0]];

   always @(posedge clk) if (mem_we) n_strobe <= n_strobe + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic to_exec();
      tick();
      tick();
   endtask

   initial begin
      n_run = 0;
      n_fail = 0;
      n_strobe = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'h8000;
      mem[10'h000] = 16'h0355;
      mem[10'h001] = 16'hD1FF;
      mem[10'h002] = 16'h12FF;
      mem[10'h003] = 16'hF412;
      mem[10'h004] = 16'h01B2;
      mem[10'h005] = 16'h4207;
      mem[10'h006] = 16'h4347;
      mem[10'h007] = 16'h8000;
      mem[10'h008] = 16'h4EC0;
      mem[10'h00E] = 16'h4EC0;
      mem[10'h010] = 16'hC0FE;
      mem[10'h011] = 16'hCF05;
      mem[10'h012] = 16'h4EC0;
      mem[10'h020] = 16'h4E81;
      mem[10'h040] = 16'hBEEF;
      mem[10'h200] = 16'h4EC0;
      mem[10'h3FF] = 16'h0000;

      rst_n = 1'b0;
      en = 1'b1;
      fl = 5'h00;
      ib = 16'h0000;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pc", pc, 16'h0000);
      chk("rst_addr", addr, 16'h0000);
      chk("rst_we", reg_we, 16'h0000);
      chk("rst_flsel", fl_sel, 1'b0);

      rst_n = 1'b1;
      #1;
      chk("fetch_addr", addr, 16'h0000);
      chk("fetch_flsel", fl_sel, 1'b1);

      // ADD R3,R5
      to_exec();
      chk("add_asel", a_sel, 4'd3);
      chk("add_bsel", b_sel, 4'd5);
      chk("add_we", reg_we, 16'h0008);
      chk("add_flsel", fl_sel, 1'b0);
      chk("add_opc", opc, 4'h5);
      tick();
      chk("add_pc", pc, 16'h0001);

      // MOVI R1,#0xFF
      to_exec();
      chk("movi_imm", imm, 16'hFFFF);
      chk("movi_isel", imm_sel, 1'b1);
      chk("movi_we", reg_we, 16'h0002);
      tick();

      // ANDI R2,#0xFF
      to_exec();
      chk("andi_imm", imm, 16'h00FF);
      chk("andi_opc", opc, 4'h1);
      tick();

      // LUI R4,#0x12
      to_exec();
      chk("lui_imm", imm, 16'h1200);
      chk("lui_we", reg_we, 16'h0010);
      tick();

      // CMP R1,R2
      to_exec();
      chk("cmp_we", reg_we, 16'h0000);
      chk("cmp_flsel", fl_sel, 1'b0);
      tick();
      chk("cmp_pc", pc, 16'h0005);

      // LOAD R2,[R7]
      ib = 16'h0040;
      to_exec();
      chk("ld_ex_we", reg_we, 16'h0000);
      chk("ld_ex_flsel", fl_sel, 1'b1);
      tick();
      chk("ld_mem_addr", addr, 16'h0040);
      tick();
      chk("ld_wb_data", rf_data, 16'hBEEF);
      chk("ld_wb_sel", rf_sel, 1'b1);
      chk("ld_wb_we", reg_we, 16'h0004);
      chk("ld_wb_pc", pc, 16'h0005);
      tick();
      chk("ld_pc", pc, 16'h0006);
      chk("ld_addr", addr, 16'h0006);

      // STOR R3,[R7] with a 4-cycle stall in S_MEM
      ib = 16'h0041;
      n_strobe = 0;
      to_exec();
      chk("st_ex_we", mem_we, 1'b0);
      tick();
      chk("st_mem_addr", addr, 16'h0041);
      chk("st_mem_we", mem_we, 1'b1);
      en = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("st_stall_we", mem_we, 1'b0);
         tick();
      end
      chk("st_stall_addr", addr, 16'h0041);
      chk("st_stall_pc", pc, 16'h0006);
      en = 1'b1;
      #1;
      chk("st_resume_we", mem_we, 1'b1);
      tick();
      chk("st_pc", pc, 16'h0007);
      chk("st_strobes", n_strobe, 32'd1);

      // undefined opcode runs as NOP
      to_exec();
      chk("nop_we", reg_we, 16'h0000);
      chk("nop_flsel", fl_sel, 1'b1);
      tick();
      chk("nop_pc", pc, 16'h0008);

      // JUC to 0x10
      ib = 16'h0010;
      to_exec();
      tick();
      chk("juc_pc", pc, 16'h0010);

      // BEQ -2 taken
      fl = 5'b01000;
      to_exec();
      chk("beq_flsel", fl_sel, 1'b1);
      tick();
      chk("beq_t_pc", pc, 16'h000E);

      ib = 16'h0010;
      to_exec();
      tick();
      chk("juc2_pc", pc, 16'h0010);

      // BEQ -2 not taken
      fl = 5'b00000;
      to_exec();
      tick();
      chk("beq_n_pc", pc, 16'h0011);

      // condition 0xF never taken
      fl = 5'h1F;
      to_exec();
      tick();
      chk("bnv_pc", pc, 16'h0012);

      ib = 16'h0020;
      to_exec();
      tick();
      chk("juc3_pc", pc, 16'h0020);

      // JAL R14,R1
      ib = 16'h0200;
      to_exec();
      chk("jal_data", rf_data, 16'h0021);
      chk("jal_sel", rf_sel, 1'b1);
      chk("jal_we", reg_we, 16'h4000);
      chk("jal_flsel", fl_sel, 1'b1);
      tick();
      chk("jal_pc", pc, 16'h0200);

      // jump to top of memory; NOP there wraps PC
      ib = 16'hFFFF;
      to_exec();
      tick();
      chk("jtop_pc", pc, 16'hFFFF);
      to_exec();
      chk("wrap_we", reg_we, 16'h0000);
      tick();
      chk("wrap_pc", pc, 16'h0000);

      // reset mid-EXECUTE of ADD
      to_exec();
      chk("add2_we", reg_we, 16'h0008);
      rst_n = 1'b0;
      #1;
      chk("mrst_we", reg_we, 16'h0000);
      chk("mrst_pc", pc, 16'h0000);
      chk("mrst_asel", a_sel, 4'd0);
      chk("mrst_flsel", fl_sel, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_addr", addr, 16'h0000);
      chk("post_flsel", fl_sel, 1'b1);
      to_exec();
      chk("post_we", reg_we, 16'h0008);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
